// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised multi-port register file with write-through bypass
// and a per-register pending-write scoreboard. Issue reserves a destination
// (busy), writeback clears it; read ports report data plus operand readiness.
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_conflict,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // Address decodes shared by the write, reserve and read paths.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              wr_ok;
  logic              rsv_ok;
  logic              same_addr;
  logic              wr_busy;
  logic              rsv_busy;
  logic              set_new;
  logic              clr_busy;
  logic [ADDR_W:0]   cnt_next;

  // Qualify writeback/reserve requests and derive the scoreboard count delta.
  always_comb begin
    wr_ok     = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
    rsv_ok    = rsv_en && in_range(rsv_addr) && !is_zero_reg(rsv_addr);
    same_addr = (wr_addr == rsv_addr);
    wr_busy   = 1'b0;
    rsv_busy  = 1'b0;
    if (wr_ok) begin
      wr_busy = busy[wr_addr];
    end
    if (rsv_ok) begin
      rsv_busy = busy[rsv_addr];
    end
    // A reservation landing on the register being written keeps it busy,
    // so that writeback does not count as a clear.
    set_new      = rsv_ok && !rsv_busy;
    clr_busy     = wr_ok && wr_busy && !(rsv_ok && same_addr);
    rsv_conflict = rsv_ok && rsv_busy && !(wr_ok && same_addr);
    cnt_next     = busy_cnt + {{ADDR_W{1'b0}}, set_new} - {{ADDR_W{1'b0}}, clr_busy};
  end

  // Register storage: writeback updates the addressed entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard: writeback clears, reservation sets (set wins on same address).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      if (wr_ok) begin
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
      busy_cnt <= cnt_next;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] port_data;
    logic              port_ready;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    // Combinational read with zero-register, out-of-range and bypass priority.
    always_comb begin
      port_data  = '0;
      port_ready = 1'b1;
      if (!in_range(addr) || is_zero_reg(addr)) begin
        port_data  = '0;
        port_ready = 1'b1;
      end else if (wr_en && (wr_addr == addr)) begin
        port_data  = wr_data;
        port_ready = 1'b1;
      end else begin
        port_data  = regs[addr];
        port_ready = !busy[addr];
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = port_data;
    assign rd_ready[p]                 = port_ready;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: self-checking bench for reg_file_sb.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;

  // Instance A: default 32x32, two read ports, zero register on.
  logic [9:0]   rd_addr_a;
  logic [63:0]  rd_data_a;
  logic [1:0]   rd_ready_a;
  logic         conf_a;
  logic [5:0]   cnt_a;

  // Instance B: 24 x 64-bit, three read ports (addresses 24..31 out of range).
  logic [14:0]  rd_addr_b;
  logic [191:0] rd_data_b;
  logic [2:0]   rd_ready_b;
  logic         conf_b;
  logic [5:0]   cnt_b;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_ready(rd_ready_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[31:0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_conflict(conf_a), .busy_cnt(cnt_a)
  );

  reg_file_sb #(.DATA_W(64), .DEPTH(24), .NUM_RD(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_ready(rd_ready_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rsv_conflict(conf_b), .busy_cnt(cnt_b)
  );

  // Expected observation for one instance in one cycle.
  typedef struct {
    int              cfg;
    logic [2:0][63:0] data;
    logic [2:0]      ready;
    logic            conf;
    logic [5:0]      cnt;
  } exp_t;

  // Hand-computed table row for instance A: stimulus then expectations.
  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        r0;
    logic        r1;
    logic        conf;
    logic [5:0]  cnt;
  } vec_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model state for both configurations.
  logic [63:0] m_reg  [2][32];
  bit          m_busy [2][32];

  // Single comparison point: every check steps tests_run / tests_failed.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus shortly after the rising edge.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                               input logic re, input logic [4:0] ra,
                               input logic [9:0] raa, input logic [14:0] rab);
    @(posedge clk);
    #1;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsv_en    = re;
    rsv_addr  = ra;
    rd_addr_a = raa;
    rd_addr_b = rab;
  endtask

  // Pop n scoreboard entries and compare them against the settled outputs.
  task automatic checkOutput(input int n);
    exp_t e;
    #1;
    repeat (n) begin
      if (sb.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL scoreboard: empty queue at time %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.cfg == 0) begin
          for (int i = 0; i < 2; i++) begin
            check($sformatf("A rd_data%0d", i), {32'h0, rd_data_a[i*32 +: 32]}, e.data[i]);
            check($sformatf("A rd_ready%0d", i), {63'h0, rd_ready_a[i]}, {63'h0, e.ready[i]});
          end
          check("A rsv_conflict", {63'h0, conf_a}, {63'h0, e.conf});
          check("A busy_cnt", {58'h0, cnt_a}, {58'h0, e.cnt});
        end else begin
          for (int i = 0; i < 3; i++) begin
            check($sformatf("B rd_data%0d", i), rd_data_b[i*64 +: 64], e.data[i]);
            check($sformatf("B rd_ready%0d", i), {63'h0, rd_ready_b[i]}, {63'h0, e.ready[i]});
          end
          check("B rsv_conflict", {63'h0, conf_b}, {63'h0, e.conf});
          check("B busy_cnt", {58'h0, cnt_b}, {58'h0, e.cnt});
        end
      end
    end
  endtask

  // Model read of config c at address a: returns {ready, data}.
  function automatic logic [64:0] model_read(input int c, input logic [4:0] a);
    int          dep = (c == 0) ? 32 : 24;
    logic [63:0] msk = (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (int'(a) >= dep || a == 5'd0) return {1'b1, 64'h0};
    if (wr_en && wr_addr == a) return {1'b1, wr_data & msk};
    return {~m_busy[c][a], m_reg[c][a]};
  endfunction

  function automatic logic [5:0] model_count(input int c);
    logic [5:0] n = '0;
    for (int i = 0; i < 32; i++) n += {5'h0, m_busy[c][i]};
    return n;
  endfunction

  // Build the expected record for config c from the model and current inputs.
  function automatic exp_t model_expect(input int c);
    exp_t        e;
    int          dep = (c == 0) ? 32 : 24;
    logic [64:0] r;
    logic [4:0]  a;
    e.cfg   = c;
    e.data  = '0;
    e.ready = '0;
    for (int i = 0; i < ((c == 0) ? 2 : 3); i++) begin
      a = (c == 0) ? rd_addr_a[i*5 +: 5] : rd_addr_b[i*5 +: 5];
      r = model_read(c, a);
      e.data[i]  = r[63:0];
      e.ready[i] = r[64];
    end
    e.conf = rsv_en && int'(rsv_addr) < dep && rsv_addr != 5'd0 && m_busy[c][rsv_addr]
             && !(wr_en && wr_addr == rsv_addr);
    e.cnt  = model_count(c);
    return e;
  endfunction

  // Advance the model by one clock edge with the current inputs.
  task automatic model_step(input int c);
    int          dep = (c == 0) ? 32 : 24;
    logic [63:0] msk = (c == 0) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    if (wr_en && int'(wr_addr) < dep && wr_addr != 5'd0) begin
      m_reg[c][wr_addr]  = wr_data & msk;
      m_busy[c][wr_addr] = 1'b0;
    end
    if (rsv_en && int'(rsv_addr) < dep && rsv_addr != 5'd0) m_busy[c][rsv_addr] = 1'b1;
  endtask

  vec_t vecs[16];
  exp_t ev;
  logic [4:0] ra0, ra1, ra2;

  initial begin
    // Table: field order we, wa, wd, re, ra, a0, a1 | d0, d1, r0, r1, conf, cnt
    vecs[0]  = '{0, 0, 32'h0,        0, 0, 5, 0, 32'h0,        32'h0,        1, 1, 0, 0};
    vecs[1]  = '{0, 0, 32'h0,        1, 5, 5, 7, 32'h0,        32'h0,        1, 1, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        0, 0, 5, 0, 32'h0,        32'h0,        0, 1, 0, 1};
    vecs[3]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1, 1, 0, 1};
    vecs[4]  = '{0, 0, 32'h0,        0, 0, 5, 0, 32'hDEADBEEF, 32'h0,        1, 1, 0, 0};
    vecs[5]  = '{1, 0, 32'h1234,     1, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        1, 7, 0, 7, 32'h0,        32'h0,        1, 1, 0, 0};
    vecs[7]  = '{1, 7, 32'hCAFE0007, 1, 7, 7, 9, 32'hCAFE0007, 32'h0,        1, 1, 0, 1};
    vecs[8]  = '{0, 0, 32'h0,        1, 7, 7, 7, 32'hCAFE0007, 32'hCAFE0007, 0, 0, 1, 1};
    vecs[9]  = '{1, 7, 32'h11,       0, 0, 7, 5, 32'h11,       32'hDEADBEEF, 1, 1, 0, 1};
    vecs[10] = '{1, 3, 32'h33,       1, 3, 3, 7, 32'h33,       32'h11,       1, 1, 0, 0};
    vecs[11] = '{0, 0, 32'h0,        0, 0, 3, 7, 32'h33,       32'h11,       0, 1, 0, 1};
    vecs[12] = '{1, 3, 32'h44,       1, 9, 3, 9, 32'h44,       32'h0,        1, 1, 0, 1};
    vecs[13] = '{1, 4, 32'h55,       0, 0, 3, 9, 32'h44,       32'h0,        1, 0, 0, 1};
    vecs[14] = '{1, 9, 32'h99,       0, 0, 4, 9, 32'h55,       32'h99,       1, 1, 0, 1};
    vecs[15] = '{0, 0, 32'h0,        0, 0, 9, 4, 32'h99,       32'h55,       1, 1, 0, 0};

    rst = 1'b1;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    rd_addr_a = 0; rd_addr_b = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: reserve/bypass, zero register, same-edge write+reserve.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, {32'h0, vecs[i].wd}, vecs[i].re, vecs[i].ra,
                    {vecs[i].a1, vecs[i].a0}, 15'h0);
      ev.cfg   = 0;
      ev.data  = '0;
      ev.data[0] = {32'h0, vecs[i].d0};
      ev.data[1] = {32'h0, vecs[i].d1};
      ev.ready = {1'b0, vecs[i].r1, vecs[i].r0};
      ev.conf  = vecs[i].conf;
      ev.cnt   = vecs[i].cnt;
      sb.push_back(ev);
      checkOutput(1);
    end

    // Fill the scoreboard with all 31 nonzero registers, one per cycle.
    for (int r = 1; r <= 31; r++) begin
      applyStimulus(0, 0, 64'h0, 1, 5'(r), 10'h0, 15'h0);
      #1;
      check($sformatf("fill cnt before rsv x%0d", r), 64'(cnt_a), 64'(r - 1));
    end
    applyStimulus(0, 0, 64'h0, 0, 0, {5'd1, 5'd31}, 15'h0);
    #1;
    check("fill cnt full", 64'(cnt_a), 64'd31);
    check("fill x31 busy", {63'h0, rd_ready_a[0]}, 64'd0);

    // Write back in reverse order: count drops by one per edge.
    for (int r = 31; r >= 1; r--) begin
      applyStimulus(1, 5'(r), 64'(r) * 64'h101, 0, 0, 10'h0, 15'h0);
      #1;
      check($sformatf("drain cnt before wr x%0d", r), 64'(cnt_a), 64'(r));
    end
    applyStimulus(0, 0, 64'h0, 0, 0, {5'd2, 5'd31}, 15'h0);
    #1;
    check("drain cnt empty", 64'(cnt_a), 64'd0);
    check("drain x31 data", {32'h0, rd_data_a[31:0]}, 64'd31 * 64'h101);

    // Reset mid-operation between edges with busy and written registers.
    for (int r = 1; r <= 4; r++) applyStimulus(0, 0, 64'h0, 1, 5'(r), 10'h0, 15'h0);
    applyStimulus(0, 0, 64'h0, 0, 0, {5'd2, 5'd10}, 15'h0);
    #1;
    check("pre-reset cnt", 64'(cnt_a), 64'd4);
    check("pre-reset x10 data", {32'h0, rd_data_a[31:0]}, 64'd10 * 64'h101);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset rd_data", {rd_data_a}, 64'h0);
    check("reset rd_ready", {62'h0, rd_ready_a}, 64'h3);
    check("reset busy_cnt", 64'(cnt_a), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Both configurations against the reference model with random traffic.
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[c][i]  = '0;
        m_busy[c][i] = 1'b0;
      end
    end
    for (int n = 0; n < 3000; n++) begin
      ra0 = 5'($urandom_range(0, 31));
      ra1 = 5'($urandom_range(0, 31));
      ra2 = 5'($urandom_range(0, 31));
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    {ra1, ra0}, {ra2, ra1, ra0});
      // Bias one read port of each instance toward the bypass path.
      if ($urandom_range(0, 3) == 0) begin
        rd_addr_a[4:0]   = wr_addr;
        rd_addr_b[14:10] = wr_addr;
      end
      sb.push_back(model_expect(0));
      sb.push_back(model_expect(1));
      checkOutput(2);
      model_step(0);
      model_step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
